// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the RV64 memory-access stage: widths, funct3 encodings,
// FSM state encoding and the access-size byte-mask helper.
package mem_access_stage_pkg;

    localparam int XLEN    = 64;
    localparam int DMEM_AW = 64;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // funct3[1:0] encodes log2 of the access size in bytes
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            2'b11:   size_mask = 8'hFF;
            default: size_mask = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Bundle of execute-side inputs, data-memory port and writeback record for the
// memory-access stage. master = the stage, slave = its surroundings.
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    alu_result;
    logic [XLEN-1:0]    store_data;
    logic               mem_read;
    logic               mem_write;
    logic [2:0]         funct3;
    logic [4:0]         rd;
    logic               reg_write;

    logic               dmem_req_valid;
    logic               dmem_req_ready;
    logic [DMEM_AW-1:0] dmem_addr;
    logic               dmem_we;
    logic [XLEN-1:0]    dmem_wdata;
    logic [7:0]         dmem_wstrb;
    logic               dmem_rsp_valid;
    logic [XLEN-1:0]    dmem_rdata;

    logic               wb_valid;
    logic [XLEN-1:0]    wb_data;
    logic [4:0]         wb_rd;
    logic               wb_reg_write;
    logic               wb_misaligned;
    logic               wb_illegal;

    modport master (
        input  in_valid, alu_result, store_data, mem_read, mem_write, funct3, rd, reg_write,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rdata,
        output in_ready,
        output dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
        output wb_valid, wb_data, wb_rd, wb_reg_write, wb_misaligned, wb_illegal
    );

    modport slave (
        output in_valid, alu_result, store_data, mem_read, mem_write, funct3, rd, reg_write,
        output dmem_req_ready, dmem_rsp_valid, dmem_rdata,
        input  in_ready,
        input  dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
        input  wb_valid, wb_data, wb_rd, wb_reg_write, wb_misaligned, wb_illegal
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store strobe/data placement, load lane
// extraction with sign/zero extension, and alignment/legality checks.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [2:0]      addr_lo,
    input  logic            is_store,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic            misaligned,
    output logic            illegal
);

    logic [5:0]      lane_shift_s;
    logic [XLEN-1:0] lane_s;
    logic            misaligned_raw_s;

    assign lane_shift_s = {addr_lo, 3'b000};

    // Place store data and strobes onto the addressed byte lanes
    always_comb begin
        wstrb = size_mask(funct3[1:0]) << addr_lo;
        wdata = store_data << lane_shift_s;
    end

    // Pull the addressed lane down to bit 0 and extend to 64 bits
    always_comb begin
        lane_s = rdata >> lane_shift_s;
        case (funct3)
            F3_LB:   load_data = {{56{lane_s[7]}},  lane_s[7:0]};
            F3_LH:   load_data = {{48{lane_s[15]}}, lane_s[15:0]};
            F3_LW:   load_data = {{32{lane_s[31]}}, lane_s[31:0]};
            F3_LD:   load_data = lane_s;
            F3_LBU:  load_data = {56'd0, lane_s[7:0]};
            F3_LHU:  load_data = {48'd0, lane_s[15:0]};
            F3_LWU:  load_data = {32'd0, lane_s[31:0]};
            default: load_data = {XLEN{1'b0}};
        endcase
    end

    // Legality by access type; misalignment is only reported for legal encodings
    always_comb begin
        illegal          = 1'b0;
        misaligned_raw_s = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_SB, F3_SH, F3_SW, F3_SD: illegal = 1'b0;
                default:                    illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LH, F3_LW, F3_LD, F3_LBU, F3_LHU, F3_LWU: illegal = 1'b0;
                default:                                           illegal = 1'b1;
            endcase
        end
        case (funct3[1:0])
            2'b00:   misaligned_raw_s = 1'b0;
            2'b01:   misaligned_raw_s = addr_lo[0];
            2'b10:   misaligned_raw_s = |addr_lo[1:0];
            2'b11:   misaligned_raw_s = |addr_lo;
            default: misaligned_raw_s = 1'b0;
        endcase
        misaligned = misaligned_raw_s & ~illegal;
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV64 memory stage: single-outstanding load/store over a valid/ready data port,
// pass-through of non-memory results, one registered writeback record per op.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    mem_access_stage_if.master bus
);

    state_t state_r, next_state_s;
    logic   accept_s, capture_rsp_s;
    logic   is_mem_s, both_ops_s, mem_illegal_s, mem_misaligned_s;

    logic [2:0] funct3_r, addr_lo_r;
    logic       is_load_r, reg_write_r;

    logic [2:0]      align_funct3_s, align_addr_s;
    logic            align_is_store_s;
    logic [7:0]      wstrb_s;
    logic [XLEN-1:0] wdata_s, load_data_s;
    logic            mis_s, ill_s;

    logic               in_ready_r, dmem_req_valid_r, dmem_we_r;
    logic [DMEM_AW-1:0] dmem_addr_r;
    logic [XLEN-1:0]    dmem_wdata_r, wb_data_r;
    logic [7:0]         dmem_wstrb_r;
    logic               wb_valid_r, wb_reg_write_r, wb_misaligned_r, wb_illegal_r;
    logic [4:0]         wb_rd_r;

    // In IDLE the aligner checks the incoming op; afterwards it serves the captured one
    always_comb begin
        if (state_r == ST_IDLE) begin
            align_funct3_s   = bus.funct3;
            align_addr_s     = bus.alu_result[2:0];
            align_is_store_s = bus.mem_write & ~bus.mem_read;
        end else begin
            align_funct3_s   = funct3_r;
            align_addr_s     = addr_lo_r;
            align_is_store_s = ~is_load_r;
        end
    end

    mem_lane_align u_lane_align (
        .funct3     (align_funct3_s),
        .addr_lo    (align_addr_s),
        .is_store   (align_is_store_s),
        .store_data (bus.store_data),
        .rdata      (bus.dmem_rdata),
        .wstrb      (wstrb_s),
        .wdata      (wdata_s),
        .load_data  (load_data_s),
        .misaligned (mis_s),
        .illegal    (ill_s)
    );

    assign is_mem_s         = bus.mem_read | bus.mem_write;
    assign both_ops_s       = bus.mem_read & bus.mem_write;
    assign mem_illegal_s    = is_mem_s & (ill_s | both_ops_s);
    assign mem_misaligned_s = is_mem_s & mis_s & ~both_ops_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; responses are only honoured at or after the request handshake
    always_comb begin
        next_state_s  = state_r;
        accept_s      = 1'b0;
        capture_rsp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept_s = 1'b1;
                    if (!is_mem_s || mem_illegal_s || mem_misaligned_s) begin
                        next_state_s = ST_WB;
                    end else begin
                        next_state_s = ST_REQ;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.dmem_req_ready) begin
                    if (bus.dmem_rsp_valid) begin
                        next_state_s  = ST_WB;
                        capture_rsp_s = 1'b1;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.dmem_rsp_valid) begin
                    next_state_s  = ST_WB;
                    capture_rsp_s = 1'b1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Captured instruction fields, memory request and writeback record
    always_ff @(posedge clk) begin
        if (reset) begin
            funct3_r         <= 3'd0;
            addr_lo_r        <= 3'd0;
            is_load_r        <= 1'b0;
            reg_write_r      <= 1'b0;
            in_ready_r       <= 1'b1;
            dmem_req_valid_r <= 1'b0;
            dmem_addr_r      <= {DMEM_AW{1'b0}};
            dmem_we_r        <= 1'b0;
            dmem_wdata_r     <= {XLEN{1'b0}};
            dmem_wstrb_r     <= 8'h00;
            wb_valid_r       <= 1'b0;
            wb_data_r        <= {XLEN{1'b0}};
            wb_rd_r          <= 5'd0;
            wb_reg_write_r   <= 1'b0;
            wb_misaligned_r  <= 1'b0;
            wb_illegal_r     <= 1'b0;
        end else begin
            in_ready_r       <= (next_state_s == ST_IDLE);
            dmem_req_valid_r <= (next_state_s == ST_REQ);
            wb_valid_r       <= (next_state_s == ST_WB);
            if (accept_s) begin
                funct3_r        <= bus.funct3;
                addr_lo_r       <= bus.alu_result[2:0];
                is_load_r       <= bus.mem_read & ~bus.mem_write;
                reg_write_r     <= bus.reg_write;
                dmem_addr_r     <= {bus.alu_result[DMEM_AW-1:3], 3'b000};
                dmem_we_r       <= bus.mem_write & ~bus.mem_read;
                dmem_wdata_r    <= wdata_s;
                dmem_wstrb_r    <= wstrb_s;
                wb_rd_r         <= bus.rd;
                wb_misaligned_r <= mem_misaligned_s;
                wb_illegal_r    <= mem_illegal_s;
                wb_data_r       <= is_mem_s ? {XLEN{1'b0}} : bus.alu_result;
                wb_reg_write_r  <= is_mem_s ? 1'b0 : bus.reg_write;
            end else if (capture_rsp_s) begin
                wb_data_r      <= is_load_r ? load_data_s : {XLEN{1'b0}};
                wb_reg_write_r <= is_load_r & reg_write_r;
            end else begin
                wb_data_r      <= wb_data_r;
                wb_reg_write_r <= wb_reg_write_r;
            end
        end
    end

    assign bus.in_ready       = in_ready_r;
    assign bus.dmem_req_valid = dmem_req_valid_r;
    assign bus.dmem_addr      = dmem_addr_r;
    assign bus.dmem_we        = dmem_we_r;
    assign bus.dmem_wdata     = dmem_wdata_r;
    assign bus.dmem_wstrb     = dmem_wstrb_r;
    assign bus.wb_valid       = wb_valid_r;
    assign bus.wb_data        = wb_data_r;
    assign bus.wb_rd          = wb_rd_r;
    assign bus.wb_reg_write   = wb_reg_write_r;
    assign bus.wb_misaligned  = wb_misaligned_r;
    assign bus.wb_illegal     = wb_illegal_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// ops checked against an arithmetic reference model.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    mem_access_stage_if bus();

    mem_access_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        timeout;
        logic        req_seen;
        logic [63:0] req_addr;
        logic        req_we;
        logic [63:0] req_wdata;
        logic [7:0]  req_wstrb;
        logic        unstable;
        logic        busy_ready;
        logic [63:0] wb_data;
        logic [4:0]  wb_rd;
        logic        wb_rw;
        logic        wb_mis;
        logic        wb_ill;
        int          latency;
        logic        wb_stuck;
    } obs_t;

    typedef struct {
        logic        access;
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] wb_data;
        logic        wb_rw;
        logic        mis;
        logic        ill;
    } exp_t;

    function automatic exp_t model(input logic [63:0] alu, input logic [63:0] sd,
                                   input logic [63:0] rdata, input logic mr, input logic mw,
                                   input logic [2:0] f3, input logic rw);
        exp_t e;
        int size, off;
        logic [63:0] v, m;
        e = '{default: 0};
        size = 1 << f3[1:0];
        off = int'(alu[2:0]);
        if (!mr && !mw) begin
            e.wb_data = alu;
            e.wb_rw = rw;
        end else if ((mr && mw) || (mw && f3 > 3'd3) || (mr && f3 == 3'd7)) begin
            e.ill = 1'b1;
        end else if ((alu % 64'(size)) != 64'd0) begin
            e.mis = 1'b1;
        end else begin
            e.access = 1'b1;
            e.addr = alu - 64'(off);
            e.we = mw;
            e.wstrb = 8'(((1 << size) - 1) << off);
            e.wdata = sd << (8 * off);
            if (mr) begin
                v = rdata >> (8 * off);
                if (size < 8) begin
                    m = (64'd1 << (8 * size)) - 64'd1;
                    v = v & m;
                    if (f3 < 3'd4 && v[8 * size - 1]) v = v | ~m;
                end
                e.wb_data = v;
                e.wb_rw = rw;
            end
        end
        return e;
    endfunction

    // Drives one instruction and plays memory; returns what the DUT did.
    task automatic do_op(input logic [63:0] alu, input logic [63:0] sd, input logic [63:0] rdata,
                         input logic mr, input logic mw, input logic [2:0] f3, input logic [4:0] rd_i,
                         input logic rw, input int stall, input int wait_c, input logic noise,
                         output obs_t o);
        int cyc, stall_cnt, wait_cnt;
        logic hs_done, done;
        o = '{default: 0};
        bus.in_valid = 1'b1;
        bus.alu_result = alu;
        bus.store_data = sd;
        bus.mem_read = mr;
        bus.mem_write = mw;
        bus.funct3 = f3;
        bus.rd = rd_i;
        bus.reg_write = rw;
        bus.dmem_req_ready = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.alu_result = ~alu;
        bus.store_data = ~sd;
        bus.funct3 = ~f3;
        bus.rd = ~rd_i;
        bus.reg_write = ~rw;
        cyc = 1; stall_cnt = 0; wait_cnt = 0; hs_done = 1'b0; done = 1'b0;
        while (!done && cyc <= 60) begin
            bus.dmem_req_ready = 1'b0;
            bus.dmem_rsp_valid = 1'b0;
            bus.dmem_rdata = {$urandom(), $urandom()};
            if (bus.in_ready) o.busy_ready = 1'b1;
            if (bus.wb_valid) begin
                o.wb_data = bus.wb_data;
                o.wb_rd = bus.wb_rd;
                o.wb_rw = bus.wb_reg_write;
                o.wb_mis = bus.wb_misaligned;
                o.wb_ill = bus.wb_illegal;
                o.latency = cyc;
                done = 1'b1;
            end else if (bus.dmem_req_valid) begin
                if (!o.req_seen) begin
                    o.req_seen = 1'b1;
                    o.req_addr = bus.dmem_addr;
                    o.req_we = bus.dmem_we;
                    o.req_wdata = bus.dmem_wdata;
                    o.req_wstrb = bus.dmem_wstrb;
                end else if (bus.dmem_addr !== o.req_addr || bus.dmem_we !== o.req_we ||
                             bus.dmem_wdata !== o.req_wdata || bus.dmem_wstrb !== o.req_wstrb) begin
                    o.unstable = 1'b1;
                end
                if (stall_cnt >= stall) begin
                    bus.dmem_req_ready = 1'b1;
                    hs_done = 1'b1;
                    if (wait_c == 0) begin
                        bus.dmem_rsp_valid = 1'b1;
                        bus.dmem_rdata = rdata;
                    end
                end else begin
                    stall_cnt++;
                    if (noise) bus.dmem_rsp_valid = 1'($urandom_range(0, 1));
                end
            end else if (hs_done) begin
                wait_cnt++;
                if (wait_cnt >= wait_c) begin
                    bus.dmem_rsp_valid = 1'b1;
                    bus.dmem_rdata = rdata;
                end
            end
            if (!done) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!done) o.timeout = 1'b1;
        bus.dmem_req_ready = 1'b0;
        bus.dmem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        o.wb_stuck = bus.wb_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.alu_result = 64'd0; bus.store_data = 64'd0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.funct3 = 3'd0; bus.rd = 5'd0;
        bus.reg_write = 1'b0; bus.dmem_req_ready = 1'b0; bus.dmem_rsp_valid = 1'b0;
        bus.dmem_rdata = 64'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        vectors++;
        if ({bus.in_ready, bus.dmem_req_valid, bus.wb_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 100", {bus.in_ready, bus.dmem_req_valid, bus.wb_valid});
        end
        vectors++;
        if ({bus.wb_data, bus.wb_rd, bus.wb_reg_write, bus.wb_misaligned, bus.wb_illegal} !== 72'd0) begin
            miscompares++;
            $display("FAIL reset_wb: got %h expected 0", {bus.wb_data, bus.wb_rd, bus.wb_reg_write, bus.wb_misaligned, bus.wb_illegal});
        end
        vectors++;
        if ({bus.dmem_addr, bus.dmem_we, bus.dmem_wdata, bus.dmem_wstrb} !== 137'd0) begin
            miscompares++;
            $display("FAIL reset_dmem: got %h expected 0", {bus.dmem_addr, bus.dmem_we, bus.dmem_wdata, bus.dmem_wstrb});
        end
    endtask

    task automatic test_passthrough();
        obs_t o;
        do_op(64'h1234, 64'hAAAA, 64'd0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1, 0, 0, 1'b0, o);
        vectors++;
        if (o.wb_data !== 64'h1234 || o.wb_rd !== 5'd5 || o.wb_rw !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_wb: got data=%h rd=%0d rw=%b expected 1234/5/1", o.wb_data, o.wb_rd, o.wb_rw);
        end
        vectors++;
        if (o.latency !== 1 || o.req_seen !== 1'b0 || o.wb_stuck !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_timing: got lat=%0d req=%b stuck=%b expected 1/0/0", o.latency, o.req_seen, o.wb_stuck);
        end
    endtask

    task automatic test_lb_sign();
        obs_t o;
        do_op(64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1'b1, 1'b0, F3_LB, 5'd7, 1'b1, 0, 1, 1'b0, o);
        vectors++;
        if (o.req_addr !== 64'h1000 || o.req_we !== 1'b0) begin
            miscompares++;
            $display("FAIL lb_addr: got %h we=%b expected 1000 we=0", o.req_addr, o.req_we);
        end
        vectors++;
        if (o.wb_data !== 64'hFFFF_FFFF_FFFF_FF80 || o.latency !== 3 || o.wb_rw !== 1'b1) begin
            miscompares++;
            $display("FAIL lb_data: got %h lat=%0d rw=%b expected ffffffffffffff80 lat=3 rw=1", o.wb_data, o.latency, o.wb_rw);
        end
        do_op(64'h1003, 64'h0, 64'h0000_0000_8000_0000, 1'b1, 1'b0, F3_LBU, 5'd7, 1'b1, 0, 1, 1'b0, o);
        vectors++;
        if (o.wb_data !== 64'h80) begin
            miscompares++;
            $display("FAIL lbu_data: got %h expected 80", o.wb_data);
        end
    endtask

    task automatic test_store();
        obs_t o;
        do_op(64'h2004, 64'hDEADBEEF, 64'd0, 1'b0, 1'b1, F3_SW, 5'd3, 1'b1, 0, 0, 1'b0, o);
        vectors++;
        if (o.req_wstrb !== 8'hF0 || o.req_wdata !== 64'hDEADBEEF_00000000 || o.req_we !== 1'b1 || o.req_addr !== 64'h2000) begin
            miscompares++;
            $display("FAIL sw_req: got strb=%h data=%h we=%b addr=%h", o.req_wstrb, o.req_wdata, o.req_we, o.req_addr);
        end
        vectors++;
        if (o.wb_rw !== 1'b0 || o.wb_data !== 64'd0 || o.latency !== 2) begin
            miscompares++;
            $display("FAIL sw_wb: got rw=%b data=%h lat=%0d expected 0/0/2", o.wb_rw, o.wb_data, o.latency);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_op(64'h3001, 64'h0, 64'h0, 1'b1, 1'b0, F3_LD, 5'd4, 1'b1, 0, 0, 1'b0, o);
        vectors++;
        if (o.req_seen !== 1'b0 || o.wb_mis !== 1'b1 || o.wb_ill !== 1'b0 || o.wb_rw !== 1'b0 || o.latency !== 1) begin
            miscompares++;
            $display("FAIL ld_misaligned: got req=%b mis=%b ill=%b rw=%b lat=%0d", o.req_seen, o.wb_mis, o.wb_ill, o.wb_rw, o.latency);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        exp_t e;
        logic [63:0] rd_word;
        rd_word = {$urandom(), $urandom()};
        e = model(64'h44, 64'h0, rd_word, 1'b1, 1'b0, F3_LW, 1'b1);
        do_op(64'h44, 64'h0, rd_word, 1'b1, 1'b0, F3_LW, 5'd9, 1'b1, 3, 2, 1'b1, o);
        vectors++;
        if (o.unstable !== 1'b0 || o.busy_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_stable: got unstable=%b in_ready_busy=%b expected 0/0", o.unstable, o.busy_ready);
        end
        vectors++;
        if (o.latency !== 7 || o.wb_data !== e.wb_data) begin
            miscompares++;
            $display("FAIL bp_wb: got lat=%0d data=%h expected 7 %h", o.latency, o.wb_data, e.wb_data);
        end
    endtask

    task automatic test_reset_in_wait();
        logic seen_wb, not_idle;
        bus.in_valid = 1'b1; bus.alu_result = 64'h5000; bus.mem_read = 1'b1; bus.mem_write = 1'b0;
        bus.funct3 = F3_LD; bus.rd = 5'd9; bus.reg_write = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.dmem_req_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_wait_req: got %b expected 1", bus.dmem_req_valid);
        end
        bus.dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        bus.dmem_req_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.dmem_rsp_valid = 1'b1;
        bus.dmem_rdata = {$urandom(), $urandom()};
        seen_wb = 1'b0; not_idle = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.wb_valid) seen_wb = 1'b1;
            if (!bus.in_ready || bus.dmem_req_valid) not_idle = 1'b1;
            @(posedge clk); #1;
            bus.dmem_rsp_valid = 1'b0;
        end
        vectors++;
        if (seen_wb !== 1'b0 || not_idle !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_wait: got wb_seen=%b not_idle=%b expected 0/0", seen_wb, not_idle);
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic [63:0] alu, sd, rdw;
        logic mr, mw, rw;
        logic [2:0] f3;
        logic [4:0] rdi;
        int kind, stall, wt, exp_lat;
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 9));
            mr = (kind >= 2 && kind <= 5) || kind == 9;
            mw = (kind >= 6);
            f3 = mw && !mr ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
            alu = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) alu = alu & ~((64'd1 << f3[1:0]) - 64'd1);
            sd = {$urandom(), $urandom()};
            rdw = {$urandom(), $urandom()};
            rdi = 5'($urandom_range(0, 31));
            rw = 1'($urandom_range(0, 1));
            stall = int'($urandom_range(0, 3));
            wt = int'($urandom_range(0, 3));
            e = model(alu, sd, rdw, mr, mw, f3, rw);
            do_op(alu, sd, rdw, mr, mw, f3, rdi, rw, stall, wt, 1'b1, o);
            exp_lat = e.access ? 2 + stall + wt : 1;
            vectors++;
            if (o.timeout !== 1'b0 || o.req_seen !== e.access) begin
                miscompares++;
                $display("FAIL rnd_req[%0d]: got timeout=%b req=%b expected 0/%b", i, o.timeout, o.req_seen, e.access);
            end
            if (e.access) begin
                vectors++;
                if (o.req_addr !== e.addr || o.req_we !== e.we || o.unstable !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_addr[%0d]: got %h we=%b unstable=%b expected %h we=%b", i, o.req_addr, o.req_we, o.unstable, e.addr, e.we);
                end
            end
            if (e.access && e.we) begin
                vectors++;
                if (o.req_wdata !== e.wdata || o.req_wstrb !== e.wstrb) begin
                    miscompares++;
                    $display("FAIL rnd_store[%0d]: got %h/%h expected %h/%h", i, o.req_wdata, o.req_wstrb, e.wdata, e.wstrb);
                end
            end
            vectors++;
            if (o.wb_data !== e.wb_data || o.wb_rd !== rdi || o.wb_rw !== e.wb_rw) begin
                miscompares++;
                $display("FAIL rnd_wb[%0d]: got %h rd=%0d rw=%b expected %h rd=%0d rw=%b", i, o.wb_data, o.wb_rd, o.wb_rw, e.wb_data, rdi, e.wb_rw);
            end
            vectors++;
            if (o.wb_mis !== e.mis || o.wb_ill !== e.ill) begin
                miscompares++;
                $display("FAIL rnd_flags[%0d]: got mis=%b ill=%b expected %b/%b", i, o.wb_mis, o.wb_ill, e.mis, e.ill);
            end
            vectors++;
            if (o.latency !== exp_lat || o.busy_ready !== 1'b0 || o.wb_stuck !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_timing[%0d]: got lat=%0d busy_ready=%b stuck=%b expected %0d/0/0", i, o.latency, o.busy_ready, o.wb_stuck, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lb_sign();
        test_store();
        test_misaligned();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of the execute stage.
- Consumes the ALU result (used as the effective address) and rs2 data (used as store data).
- Performs RV64 loads and stores through a single-outstanding valid/ready data-memory port.
- Passes non-memory results through unchanged and presents one registered writeback record per instruction.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- DMEM_AW, 64, width of the data-memory byte address.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  execute presents an instruction.
- in_ready  out  1  stage can accept; high only in IDLE.
- alu_result  in  XLEN  effective address, or result for non-memory ops.
- store_data  in  XLEN  rs2 value.
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- funct3  in  3  access size and signedness.
- rd  in  5  destination register.
- reg_write  in  1  instruction writes rd.
- dmem_req_valid  out  1  memory request pending.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_addr  out  DMEM_AW  8-byte-aligned address ({addr[63:3],3'b0}).
- dmem_we  out  1  1 = store.
- dmem_wdata  out  XLEN  store data shifted to the byte lane.
- dmem_wstrb  out  8  byte enables.
- dmem_rsp_valid  in  1  read data / write acknowledge.
- dmem_rdata  in  XLEN  aligned 64-bit read word.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_data  out  XLEN  load result or passed-through alu_result.
- wb_rd  out  5  destination register.
- wb_reg_write  out  1  write enable, already qualified by exceptions.
- wb_misaligned  out  1  access was misaligned; no memory access occurred.
- wb_illegal  out  1  funct3 is invalid for the access type.

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0 except in_ready=1.
  - Captured fields are cleared.
- States: IDLE, REQ, WAIT, WB.
- IDLE:
  - Accept on in_valid&in_ready and register all inputs.
  - Non-memory op (mem_read=mem_write=0) goes to WB.
  - A memory op with a misaligned or illegal access goes to WB with the matching flag set and wb_reg_write=0.
  - Otherwise go to REQ.
  - If mem_read and mem_write are both 1, treat the instruction as illegal.
- Alignment rules:
  - Halfword: addr[0]=0.
  - Word: addr[1:0]=0.
  - Doubleword: addr[2:0]=0.
  - Byte accesses are always aligned.
- Valid funct3 encodings:
  - Loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
  - Stores: 000 sb, 001 sh, 010 sw, 011 sd.
  - Any other funct3 is illegal.
- REQ:
  - dmem_req_valid=1; addr, we, wdata and wstrb are held stable until dmem_req_ready.
  - On handshake go to WAIT. If dmem_rsp_valid arrives in the same cycle as the handshake, go straight to WB and capture the data.
- WAIT:
  - Hold until dmem_rsp_valid, then capture dmem_rdata and go to WB.
  - No timeout.
- WB:
  - wb_valid=1 for exactly one cycle, then return to IDLE.
  - wb_data for a load is the selected lane, sign- or zero-extended to 64 bits.
  - wb_data for a store is 0 and wb_reg_write=0.
  - wb_data for a non-memory op is alu_result.
- Store lanes:
  - wstrb = size mask << addr[2:0].
  - wdata = store_data << (8*addr[2:0]).
- Latency (accept to wb_valid):
  - Non-memory or faulting: 1 cycle.
  - Memory: 2 cycles + req stall cycles + response wait cycles.
- Throughput is one instruction per 2 cycles minimum; in_ready=0 in REQ, WAIT and WB.
- dmem_rsp_valid outside WAIT (or the REQ handshake cycle) is ignored.
- Reset mid-operation:
  - Return to IDLE immediately and discard the instruction.
  - No writeback is produced, and a late response is ignored.
- rd=0 is passed through unchanged; x0 is suppressed by the register file.

Decomposition:
- Shared package holds:
  - funct3 load/store encodings as localparams.
  - The state encoding (2 bits).
  - XLEN.
- One combinational sub-module, mem_lane_align. Inputs: funct3, addr[2:0], store_data, dmem_rdata. Outputs: wstrb, shifted wdata, extended load data, misaligned, illegal.

Test Plan:
- Non-memory pass-through:
  - Stimulus: alu_result=0x1234, reg_write=1, rd=5.
  - Required: wb_valid one cycle later, wb_data=0x1234, wb_rd=5, and dmem_req_valid never asserted.
- lb sign extension:
  - Stimulus: addr=0x1003; memory returns rdata=0x0000_0000_8000_0000 with ready and rsp after 1 wait cycle.
  - Required: dmem_addr=0x1000 and wb_data=0xFFFF_FFFF_FFFF_FF80.
  - Repeat with lbu: wb_data=0x80.
- sw at 0x2004 with store_data=0xDEADBEEF:
  - Required: wstrb=0xF0, wdata=0xDEADBEEF_00000000, we=1, wb_reg_write=0.
- Misaligned ld at 0x3001:
  - Required: no dmem request, wb_misaligned=1, wb_reg_write=0, wb_valid 1 cycle after accept.
- Backpressure:
  - Stimulus: dmem_req_ready held low for 3 cycles.
  - Required: request signals stable throughout, in_ready=0, and the writeback arrives after the stall.
- Reset asserted in WAIT, followed by a late dmem_rsp_valid:
  - Required: no wb_valid, state IDLE, in_ready=1.
